// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control and display path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  localparam int CLK_HZ_DEF  = 50_000_000;
  localparam int TICK_HZ_DEF = 1000;

  // Display path codes: blank digit and offset that turns on the decimal point.
  localparam logic [4:0] HEX_BLANK = 5'b10100;
  localparam logic [4:0] DP_OFFSET = 5'b01010;

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Two-flop synchroniser, ms-strobed debouncer and press pulse for one
// active-low push-button. After reset the key must be seen released for
// DEBOUNCE_MS strobes before any press is reported, so a key held through
// reset does not produce a press until it is released and pressed again.
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic ms_strobe,
  input  logic key_n,
  output logic press
);

  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_MS must be in 1..255");
  end

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_MS - 1);

  logic       sync_p0;
  logic       sync_p1;
  logic       level;
  logic       armed;
  logic [7:0] cnt;

  // Bring the asynchronous key into the clk domain; idles released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce on ms strobes; pulse press on an accepted 1->0 of the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b1;
      armed <= 1'b0;
      cnt   <= 8'd0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (ms_strobe) begin
        if (!armed) begin
          if (!sync_p1) begin
            cnt <= 8'd0;
          end else if (cnt == DEB_LAST) begin
            armed <= 1'b1;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end else if (sync_p1 == level) begin
          cnt <= 8'd0;
        end else if (cnt == DEB_LAST) begin
          level <= sync_p1;
          cnt   <= 8'd0;
          press <= ~sync_p1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: 1 ms prescaler, two debounced keys and the
// idle/running/paused FSM that gates tick_ms and issues clear_pulse.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int TICK_HZ     = TICK_HZ_DEF,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic       tick_ms,
  output logic       clear_pulse,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DIV - 1);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an exact integer >= 2");
  end

  logic [CNT_W-1:0] pre_cnt;
  logic             ms_strobe;
  logic             start_press;
  logic             clear_press;
  state_t           st;

  assign ms_strobe = (pre_cnt == PRE_LAST);
  assign state     = st;

  // Free-running prescaler; never realigned to key events.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (ms_strobe) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_start (
    .clk       (clk),
    .reset     (reset),
    .ms_strobe (ms_strobe),
    .key_n     (key_start_n),
    .press     (start_press)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_clear (
    .clk       (clk),
    .reset     (reset),
    .ms_strobe (ms_strobe),
    .key_n     (key_clear_n),
    .press     (clear_press)
  );

  // Run/pause/idle FSM with registered outputs; clear beats start except
  // while running, where clear is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      running     <= 1'b0;
      tick_ms     <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      tick_ms     <= ms_strobe && (st == RUNNING);
      clear_pulse <= 1'b0;
      case (st)
        IDLE: begin
          if (clear_press) begin
            clear_pulse <= 1'b1;
          end else if (start_press) begin
            st      <= RUNNING;
            running <= 1'b1;
          end
        end
        RUNNING: begin
          if (start_press) begin
            st      <= PAUSED;
            running <= 1'b0;
          end
        end
        PAUSED: begin
          if (clear_press) begin
            st          <= IDLE;
            clear_pulse <= 1'b1;
          end else if (start_press) begin
            st      <= RUNNING;
            running <= 1'b1;
          end
        end
        default: begin
          st      <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and DEBOUNCE_MS=3.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic       tick_ms;
  logic       clear_pulse;
  logic       running;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int clr_cnt  = 0;
  int run_entries = 0;
  logic [1:0] prev_state = 2'b00;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ      (10000),
    .TICK_HZ     (1000),
    .DEBOUNCE_MS (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .tick_ms     (tick_ms),
    .clear_pulse (clear_pulse),
    .running     (running),
    .state       (state)
  );

  task automatic step();
    @(negedge clk);
    if (tick_ms === 1'b1) tick_cnt++;
    if (clear_pulse === 1'b1) clr_cnt++;
    if (state === 2'b01 && prev_state !== 2'b01) run_entries++;
    prev_state = state;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    tick_cnt = 0;
    clr_cnt = 0;
    run_entries = 0;
  endtask

  task automatic press_key(input bit is_clear, input int hold, input int rel);
    if (is_clear) key_clear_n = 1'b0; else key_start_n = 1'b0;
    steps(hold);
    key_clear_n = 1'b1;
    key_start_n = 1'b1;
    steps(rel);
  endtask

  task automatic test_reset();
    int last;
    int bad;
    int nstrobe;
    reset = 1'b1;
    steps(3);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    n_checks++; if (tick_ms !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick_ms); end
    n_checks++; if (clear_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %b expected 0", clear_pulse); end
    reset = 1'b0;
    clear_counts();
    last = -1; bad = 0; nstrobe = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (dut.ms_strobe === 1'b1) begin
        if (last >= 0 && (i - last) != 10) bad++;
        last = i;
        nstrobe++;
      end
    end
    n_checks++; if (nstrobe != 20) begin n_fail++; $display("FAIL idle_strobe_count: got %0d expected 20", nstrobe); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_strobe_period: got %0d bad intervals expected 0", bad); end
    n_checks++; if (tick_cnt != 0) begin n_fail++; $display("FAIL idle_ticks: got %0d expected 0", tick_cnt); end
    n_checks++; if (clr_cnt != 0) begin n_fail++; $display("FAIL idle_clear: got %0d expected 0", clr_cnt); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL idle_state: got %b expected 00", state); end
  endtask

  task automatic test_start();
    int d;
    clear_counts();
    key_start_n = 1'b0;
    d = 0;
    while (state !== 2'b01 && d < 60) begin
      step();
      d++;
    end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL start_state: got %b expected 01 (waited %0d clk)", state, d); end
    n_checks++; if (d < 20 || d > 45) begin n_fail++; $display("FAIL start_latency: got %0d clk expected 20..45", d); end
    if (d < 50) steps(50 - d);
    key_start_n = 1'b1;
    steps(50);
    n_checks++; if (run_entries != 1) begin n_fail++; $display("FAIL start_entries: got %0d expected 1", run_entries); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b expected 1", running); end
    clear_counts();
    steps(100);
    n_checks++; if (tick_cnt != 10) begin n_fail++; $display("FAIL run_ticks: got %0d expected 10", tick_cnt); end
  endtask

  task automatic test_pause_clear();
    clear_counts();
    press_key(1'b0, 50, 50);
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL pause_state: got %b expected 10", state); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b expected 0", running); end
    clear_counts();
    steps(50);
    n_checks++; if (tick_cnt != 0) begin n_fail++; $display("FAIL pause_ticks: got %0d expected 0", tick_cnt); end
    clear_counts();
    press_key(1'b1, 50, 50);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL paused_clear_state: got %b expected 00", state); end
    n_checks++; if (clr_cnt != 1) begin n_fail++; $display("FAIL paused_clear_pulses: got %0d expected 1", clr_cnt); end
    clear_counts();
    press_key(1'b1, 50, 50);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL idle_clear_state: got %b expected 00", state); end
    n_checks++; if (clr_cnt != 1) begin n_fail++; $display("FAIL idle_clear_pulses: got %0d expected 1", clr_cnt); end
    press_key(1'b0, 50, 50);
    clear_counts();
    press_key(1'b1, 50, 50);
    n_checks++; if (clr_cnt != 0) begin n_fail++; $display("FAIL run_clear_pulses: got %0d expected 0", clr_cnt); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_clear_state: got %b expected 01", state); end
    press_key(1'b0, 50, 50);
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL repause_state: got %b expected 10", state); end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    key_start_n = 1'b0;
    key_clear_n = 1'b0;
    steps(50);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    steps(50);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL both_state: got %b expected 00", state); end
    n_checks++; if (clr_cnt != 1) begin n_fail++; $display("FAIL both_clear_pulses: got %0d expected 1", clr_cnt); end
    n_checks++; if (run_entries != 0) begin n_fail++; $display("FAIL both_run_entries: got %0d expected 0", run_entries); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL both_running: got %b expected 0", running); end
  endtask

  task automatic test_glitch();
    int g;
    clear_counts();
    g = 0;
    while (dut.ms_strobe !== 1'b1 && g < 20) begin
      step();
      g++;
    end
    // Place each 5-clk release window around a strobe so the count is cleared.
    steps(6);
    for (int k = 0; k < 5; k++) begin
      key_start_n = 1'b1;
      steps(5);
      key_start_n = 1'b0;
      steps(15);
    end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL glitch_state: got %b expected 00", state); end
    n_checks++; if (run_entries != 0) begin n_fail++; $display("FAIL glitch_entries: got %0d expected 0", run_entries); end
    steps(40);
    key_start_n = 1'b1;
    steps(50);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL glitch_hold_state: got %b expected 01", state); end
    n_checks++; if (run_entries != 1) begin n_fail++; $display("FAIL glitch_hold_entries: got %0d expected 1", run_entries); end
  endtask

  task automatic test_reset_mid_press();
    key_start_n = 1'b0;
    steps(10);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL midpress_pre_state: got %b expected 01", state); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL midpress_reset_state: got %b expected 00", state); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL midpress_reset_running: got %b expected 0", running); end
    n_checks++; if (tick_ms !== 1'b0) begin n_fail++; $display("FAIL midpress_reset_tick: got %b expected 0", tick_ms); end
    n_checks++; if (clear_pulse !== 1'b0) begin n_fail++; $display("FAIL midpress_reset_clear: got %b expected 0", clear_pulse); end
    clear_counts();
    steps(100);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL midpress_held_state: got %b expected 00", state); end
    n_checks++; if (run_entries != 0) begin n_fail++; $display("FAIL midpress_held_entries: got %0d expected 0", run_entries); end
    key_start_n = 1'b1;
    steps(50);
    press_key(1'b0, 50, 20);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL midpress_repress_state: got %b expected 01", state); end
    n_checks++; if (run_entries != 1) begin n_fail++; $display("FAIL midpress_repress_entries: got %0d expected 1", run_entries); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_clear();
    test_simultaneous();
    test_glitch();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
